// File: rtl/dnn_accel_pio_pkg.sv
// Shared constants for the PIO edge-capture input port: register word addresses and edge-type encodings.
package dnn_accel_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/dnn_accel_pio_debounce.sv
// Single-bit debouncer: output follows input only after it has differed for DEBOUNCE_CYCLES cycles.
// Latency: DEBOUNCE_CYCLES cycles from a stable input change to the output.
// Backpressure: none, free-running every clock.
module dnn_accel_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_out;

    // Any cycle where the input agrees with the output restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_in != r_out) begin
            if (r_cnt == CNT_LAST) begin
                r_out <= i_in;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/dnn_accel_pio_in_edge.sv
// Avalon-MM PIO input port: synchronise, optionally debounce (DNN_PIO_DEBOUNCE_EN), capture edges, level irq.
// Latency: DATA after SYNC_STAGES+1 cycles (SYNC_STAGES+DEBOUNCE_CYCLES debounced); readdata 1 cycle.
// Backpressure: none; slave accepts every read/write with fixed latency.
module dnn_accel_pio_in_edge
    import dnn_accel_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic             w_wr_mask;
    logic             w_wr_clr;
    logic             w_unused;

    // read is informational only; readdata is produced every clock.
    assign w_unused = ^{read, writedata};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

`ifdef DNN_PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        dnn_accel_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .i_in (w_sync_in[g]),
            .o_out(w_cond[g])
        );
    end
`else
    logic [WIDTH-1:0] r_cond;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond <= '0;
        end else begin
            r_cond <= w_sync_in;
        end
    end

    assign w_cond = r_cond;
`endif

    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign w_edge = ~w_cond & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign w_edge = w_cond ^ r_prev;
    end else begin : g_rise
        assign w_edge = w_cond & ~r_prev;
    end

    assign w_wr_mask = write && (address == ADDR_IRQMASK);
    assign w_wr_clr  = write && (address == ADDR_EDGECAP);
    assign w_clr     = w_wr_clr ? writedata[WIDTH-1:0] : '0;

    // Mux sees pre-update register values, so a same-cycle write returns old data.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux = 32'(w_cond);
            ADDR_IRQMASK: w_rd_mux = 32'(r_irqmask);
            ADDR_EDGECAP: w_rd_mux = 32'(r_edgecap);
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_prev <= w_cond;
            if (w_wr_mask) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            // OR-ing the new edge after the clear lets a same-cycle edge win.
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            r_irq      <= |(r_edgecap & r_irqmask);
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_dnn_accel_pio_in_edge.sv
module tb_dnn_accel_pio_in_edge;

    localparam int SYNC = 2;
    localparam int DB   = 16;
`ifdef DNN_PIO_DEBOUNCE_EN
    localparam int LAT = SYNC + DB;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dnn_accel_pio_in_edge #(
        .WIDTH(8),
        .SYNC_STAGES(SYNC),
        .EDGE_TYPE(0),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .in_port  (in_port),
        .readdata (readdata),
        .irq      (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        d    = readdata;
        read = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq got %0b want 0", irq);
        end
        for (int a = 0; a < 4; a++) begin
            do_read(2'(a), d);
            n_cmp++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_read addr %0d got %h want 00000000", a, d);
            end
        end
    endtask

    task automatic test_data_path();
        logic [31:0] d;
        address = 2'd0; read = 1'b1;
        in_port = 8'hA5;
        repeat (LAT) tick();
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL data_early got %h want 00000000", readdata);
        end
        tick();
        n_cmp++;
        if (readdata !== 32'h000000A5) begin
            n_fail++; $display("FAIL data_value got %h want 000000a5", readdata);
        end
        repeat (3) tick();
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h000000A5) begin
            n_fail++; $display("FAIL data_rise_cap got %h want 000000a5", d);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL data_masked_irq got %0b want 0", irq);
        end
        in_port = 8'h00;
        repeat (LAT + 3) tick();
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h000000A5) begin
            n_fail++; $display("FAIL fall_ignored got %h want 000000a5", d);
        end
        do_write(2'd3, 32'hFF);
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL w1c_all got %h want 00000000", d);
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d;
        do_write(2'd2, 32'h1);
        do_read(2'd2, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL irqmask_rd got %h want 00000001", d);
        end
        in_port = 8'h01;
        repeat (LAT + 1) tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_early got %0b want 0", irq);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise got %0b want 1", irq);
        end
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL cap_bit0 got %h want 00000001", d);
        end
        do_write(2'd3, 32'h1);
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear got %0b want 0", irq);
        end
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL cap_clear got %h want 00000000", d);
        end
        do_write(2'd2, 32'h0);
        in_port = 8'h03;
        repeat (LAT + 3) tick();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked got %0b want 0", irq);
        end
        do_write(2'd2, 32'h2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL unmask_early got %0b want 0", irq);
        end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL unmask_irq got %0b want 1", irq);
        end
        do_write(2'd3, 32'hFF);
        do_write(2'd2, 32'h0);
    endtask

    task automatic test_set_clear();
        logic [31:0] d;
        in_port = 8'h0B;
        repeat (LAT + 3) tick();
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL cap_bit3 got %h want 00000008", d);
        end
        in_port = 8'h03;
        repeat (LAT + 3) tick();
        in_port = 8'h0B;
        repeat (LAT) tick();
        do_write(2'd3, 32'h8);
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h8) begin
            n_fail++; $display("FAIL set_wins got %h want 00000008", d);
        end
        do_write(2'd3, 32'h8);
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL clear_no_edge got %h want 00000000", d);
        end
    endtask

    task automatic test_reserved_rw();
        logic [31:0] d;
        do_write(2'd1, 32'hFFFF_FFFF);
        do_read(2'd1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rsvd_read got %h want 00000000", d);
        end
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd0, d);
        n_cmp++;
        if (d !== 32'h0000000B) begin
            n_fail++; $display("FAIL data_ro got %h want 0000000b", d);
        end
        do_write(2'd2, 32'hFFFF_FF5A);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_during_wr got %h want 00000000", readdata);
        end
        do_read(2'd2, d);
        n_cmp++;
        if (d !== 32'h0000005A) begin
            n_fail++; $display("FAIL mask_width got %h want 0000005a", d);
        end
        do_write(2'd2, 32'h0);
    endtask

`ifdef DNN_PIO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] d;
        address = 2'd0; read = 1'b1;
        in_port = 8'h0F;
        repeat (10) tick();
        in_port = 8'h0B;
        repeat (LAT + 4) tick();
        n_cmp++;
        if (readdata[2] !== 1'b0) begin
            n_fail++; $display("FAIL glitch_data got %0b want 0", readdata[2]);
        end
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL glitch_cap got %h want 00000000", d);
        end
        address = 2'd0;
        in_port = 8'h0F;
        repeat (LAT) tick();
        n_cmp++;
        if (readdata[2] !== 1'b0) begin
            n_fail++; $display("FAIL db_early got %0b want 0", readdata[2]);
        end
        tick();
        n_cmp++;
        if (readdata[2] !== 1'b1) begin
            n_fail++; $display("FAIL db_stable got %0b want 1", readdata[2]);
        end
        in_port = 8'h0B;
        repeat (LAT + 4) tick();
        do_write(2'd3, 32'hFF);
    endtask
`endif

    task automatic test_mid_reset();
        logic [31:0] d;
        in_port = 8'h00;
        repeat (LAT + 3) tick();
        do_write(2'd3, 32'hFF);
        in_port = 8'hFF;
        repeat (LAT + 3) tick();
        do_read(2'd3, d);
        n_cmp++;
        if (d !== 32'hFF) begin
            n_fail++; $display("FAIL cap_all got %h want 000000ff", d);
        end
        do_write(2'd2, 32'hFF);
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_all got %0b want 1", irq);
        end
        address = 2'd3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset irq %0b rd %h want 0 00000000", irq, readdata);
        end
        tick();
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_cap got %h want 00000000", readdata);
        end
        address = 2'd2;
        tick();
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_mask got %h want 00000000", readdata);
        end
        address = 2'd3;
        repeat (LAT - 1) tick();
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++; $display("FAIL no_spurious got %h want 00000000", readdata);
        end
        tick();
        n_cmp++;
        if (readdata !== 32'hFF) begin
            n_fail++; $display("FAIL recapture got %h want 000000ff", readdata);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rst_irq_masked got %0b want 0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_data_path();
        test_rise_irq();
        test_set_clear();
        test_reserved_rw();
`ifdef DNN_PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dnn_accel_pio_in_edge.md
Name: dnn_accel_pio_in_edge

Overview:
Parametrised Avalon-MM slave input port, the next generation of the system's switch/button PIO readers. It synchronises up to 32 asynchronous input bits and optionally debounces them. It also latches configurable edges into a sticky capture register and raises a maskable level interrupt. It sits on the Nios/host data bus beside the DNN accelerator, serving switches, push-buttons and status lines.

Parameters:
WIDTH, 8, number of input bits (1..32).
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (2..4).
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
DEBOUNCE_CYCLES, 16, stable-cycle count before a debounced bit changes (used only with DEBOUNCE_EN; 2..65535).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous active-high reset.
address  in  2  word address of register.
read  in  1  read strobe (informational; readdata is valid regardless).
write  in  1  write strobe.
writedata  in  32  write data.
in_port  in  WIDTH  asynchronous external inputs.
readdata  out  32  registered read data.
irq  out  1  interrupt request, active high, level.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Register map (word addresses):
  - 0: DATA. Read-only; returns the conditioned input value.
  - 1: reserved; reads 0 and ignores writes.
  - 2: IRQMASK. Read/write; bits [WIDTH-1:0].
  - 3: EDGECAP. Read; write-1-to-clear per bit.
- readdata bits [31:WIDTH] are always 0.
- Synchroniser: in_port passes through a SYNC_STAGES flop chain. The output of the chain is sync_in.
- Conditioned value cond:
  - Without the optional feature, cond = sync_in.
  - cond is registered, so an input change reaches DATA after SYNC_STAGES+1 cycles.
- Edge detection per bit, using prev = cond delayed by one cycle:
  - Rising edge: cond & ~prev.
  - Falling edge: ~cond & prev.
  - Any edge: cond ^ prev.
- EDGECAP update:
  - A detected edge sets its bit.
  - A write to address 3 clears every bit where writedata is 1.
  - If an edge and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- IRQMASK: a write to address 2 loads writedata[WIDTH-1:0].
- irq is registered: irq <= |(EDGECAP & IRQMASK), one cycle after the contributing state.
  - Unmasking an already-captured bit raises irq on the following cycle.
- Read latency is 1:
  - readdata <= mux(address) every clock.
  - The mux selects the register value before that cycle's update, so a write and a read in the same cycle return the old value.
- Reset values (all zero): readdata, irq, IRQMASK, EDGECAP, the synchroniser chain, cond, prev and debounce state.
  - Reset mid-operation discards pending edges and any partially elapsed debounce count.
  - In the first cycle after reset no edge is flagged, because prev and cond both start at 0. A 1 held on the input produces a rising edge only once it propagates to cond.
- Writes to addresses 0 and 1 have no effect.

Optional Feature:
DNN_PIO_DEBOUNCE_EN.
- Defined: each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While sync_in differs from cond, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, cond takes sync_in and the counter clears.
  - Any cycle with sync_in equal to cond clears the counter, so a glitch shorter than DEBOUNCE_CYCLES is never seen.
  - Total latency is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Undefined: no counters are built, cond = sync_in registered, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package dnn_accel_pio_pkg holds:
  - Register address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - The EDGE_TYPE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, dnn_accel_pio_debounce: a single-bit debouncer parametrised by DEBOUNCE_CYCLES, instantiated WIDTH times in a generate loop. It is instantiated only under DNN_PIO_DEBOUNCE_EN.

Test Plan:
1. Reset/defaults: reset=1 for 3 cycles, then read addresses 0..3 -> readdata=0 for all; irq=0.
2. DATA path (no debounce, WIDTH=8): in_port=8'hA5 held, wait 4 cycles, read address 0 -> readdata=32'h000000A5 one cycle after the read is issued.
3. Rising capture and irq (EDGE_TYPE=0): write IRQMASK=8'h01, toggle in_port[0] 0->1 -> EDGECAP reads 8'h01 and irq=1. Write 32'h1 to address 3 -> EDGECAP=0 and irq=0 next cycle.
4. Simultaneous set/clear: with EDGECAP[3]=1, time a new in_port[3] rising edge to reach cond in the same cycle as a write of 32'h8 to address 3 -> EDGECAP[3] remains 1.
5. Debounce (DNN_PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
   - 10-cycle pulse on in_port[2] -> DATA[2] stays 0 and EDGECAP stays 0.
   - Stable high -> DATA[2]=1 exactly 18 cycles after the input change.
6. Mid-operation reset: capture edges so EDGECAP=8'hFF and IRQMASK=8'hFF, then assert reset for 1 cycle -> EDGECAP=0, IRQMASK=0, irq=0; no spurious capture while in_port is held at 8'hFF.
